reg_scoreboard: RTL
===================

Name: reg_scoreboard

Overview:
- Register scoreboard in the decode stage, directly downstream of the decode register-control logic.
- Consumes the decoded source addresses, read enables and destination of the instruction in ID, and tracks in-flight writes per architectural register.
- Asserts stall on RAW or WAW-overflow hazards and issues the instruction to EX when it is clear; entries are retired by the writeback stage.

Parameters:
- CNT_W, 2, width of per-register pending-write counter; max in-flight writes per register = 2^CNT_W-1.
- WB_BYPASS, 1, when 1 a same-cycle writeback to a source register with count==1 clears the hazard (register file is write-through).

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- id_valid  in  1  valid instruction present in ID
- id_flush  in  1  squash the ID instruction this cycle
- rs1_addr  in  5  source 1 (r_t)
- rs2_addr  in  5  source 2 (r_t)
- rs1_rden  in  1  source 1 read enable
- rs2_rden  in  1  source 2 read enable
- rd_addr  in  5  destination register
- rd_wren  in  1  instruction writes rd
- wb_valid  in  1  writeback retiring a register write
- wb_rd_addr  in  5  writeback destination
- stall  out  1  hold IF/ID; combinational
- issue  out  1  ID instruction advances to EX this cycle; combinational
- busy_vec  out  32  bit i = counter[i]!=0; bit 0 always 0; registered
- sb_err  out  1  sticky: writeback to a register with count 0

Behaviour:
- Clock and reset: one clock `clk`; reset `rst_n` is asynchronous, active-low.
- Reset: all counters 0, busy_vec=0, sb_err=0. Reset mid-operation drops all pending entries immediately.
- x0 is never tracked. Reads of x0 never hazard; rd_wren with rd_addr=0 does not count.
- src_busy(r, en): en && r!=0 && cnt[r]!=0, except when WB_BYPASS=1 && wb_valid && wb_rd_addr==r && cnt[r]==1, which evaluates to 0.
- raw = src_busy(rs1) | src_busy(rs2).
- waw_ovf = rd_wren && rd_addr!=0 && cnt[rd_addr]==max && !(wb_valid && wb_rd_addr==rd_addr).
- stall = id_valid && !id_flush && (raw | waw_ovf).
- issue = id_valid && !id_flush && !stall.
- Zero-latency decision: issue/stall are valid in the same cycle as the ID inputs.
- inc = issue && rd_wren && rd_addr!=0. dec = wb_valid && wb_rd_addr!=0 && cnt[wb_rd_addr]!=0.
- Per register, next-edge update:
  - inc only: +1
  - dec only: -1
  - both to the same register: unchanged
  - to different registers: each applied independently
- Counters never wrap; waw_ovf guarantees no increment at max.
- wb_valid to a register with count 0: no change, sb_err set until reset.
- id_flush: no issue and no counter increment; writeback still processed.
- Stall with no writeback pending cannot deadlock; the bench treats a stall lasting more than 64 cycles with no wb_valid as an error.
- busy_vec reflects post-update counters one cycle after the causing edge.

Decomposition:
- Package defines: add SB_CNT_W (default 2) and typedef sb_cnt_t = logic [SB_CNT_W-1:0]; reuse r_t.
- Sub-module sb_counter: saturating up/down counter with inc, dec, is_zero, is_one, is_max; generated for registers 1..31.
- Hazard compare and issue logic stay in reg_scoreboard.

Test Plan:
- Reset, then ID instruction rs1=5, rd=6 with all counts 0 -> issue=1, stall=0; next cycle busy_vec[6]=1.
- Issue rd=6, then next instruction reads rs1=6 -> stall=1 until wb_valid wb_rd_addr=6. With WB_BYPASS=1, issue=1 in the writeback cycle; cnt[6]=0 afterwards.
- CNT_W=2: three issues writing rd=7, no writeback, then a fourth writing rd=7 -> stall=1. A writeback to 7 in the same cycle -> issue=1, cnt[7] stays 3.
- Same-cycle issue writing rd=8 and wb_valid wb_rd_addr=8 with cnt[8]=1 -> cnt[8] remains 1 and busy_vec[8]=1.
- id_flush=1 with id_valid=1 and rd=9 -> issue=0, stall=0, cnt[9] unchanged. rd=0 and rs1=0 -> never stall, busy_vec[0]=0.
- wb_valid wb_rd_addr=10 with cnt[10]=0 -> sb_err=1 and stays 1. Assert rst_n=0 mid-stall -> stall drops, busy_vec=0, sb_err=0 immediately.

Source files
------------

// File: rtl/reg_scoreboard_pkg.sv
// reg_scoreboard_pkg
//   Shared types and constants for the decode-stage register scoreboard.
//   SB_CNT_W  : default width of each per-register pending-write counter
//   sb_cnt_t  : counter value type at the default width
//   r_t       : architectural register address (x0..x31)
package reg_scoreboard_pkg;

  localparam int SB_CNT_W = 2;
  localparam int NUM_REGS = 32;

  typedef logic [SB_CNT_W-1:0] sb_cnt_t;
  typedef logic [4:0]          r_t;

endpackage

// File: rtl/sb_counter.sv
// sb_counter
//   Saturating up/down counter tracking in-flight writes to one register.
//   Simultaneous inc and dec cancel, so the count is left unchanged.
//   Ports:
//     clk, rst_n   : clock, asynchronous active-low reset
//     i_inc, i_dec : count up / count down this edge
//     o_is_zero    : count == 0
//     o_is_one     : count == 1
//     o_is_max     : count == 2^W-1
module sb_counter
  import reg_scoreboard_pkg::*;
#(
  parameter int W = SB_CNT_W
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_inc,
  input  logic i_dec,
  output logic o_is_zero,
  output logic o_is_one,
  output logic o_is_max
);

  localparam logic [W-1:0] CNT_MAX = '1;
  localparam logic [W-1:0] CNT_ONE = W'(1);

  logic [W-1:0] r_cnt;

  // Saturation guards keep the counter from wrapping even if a caller
  // misbehaves; the scoreboard already blocks inc at max and dec at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_inc && !i_dec && (r_cnt != CNT_MAX)) begin
      r_cnt <= r_cnt + CNT_ONE;
    end else if (i_dec && !i_inc && (r_cnt != '0)) begin
      r_cnt <= r_cnt - CNT_ONE;
    end
  end

  assign o_is_zero = (r_cnt == '0);
  assign o_is_one  = (r_cnt == CNT_ONE);
  assign o_is_max  = (r_cnt == CNT_MAX);

endmodule

// File: rtl/reg_scoreboard.sv
// reg_scoreboard
//   Decode-stage register scoreboard. Counts in-flight writes per register,
//   stalls ID on RAW hazards or when a destination counter is saturated,
//   and retires entries on writeback.
//   Ports:
//     clk, rst_n            : clock, asynchronous active-low reset
//     id_valid, id_flush    : ID instruction present / squashed
//     rs1_addr/rs1_rden     : source 1 address and read enable
//     rs2_addr/rs2_rden     : source 2 address and read enable
//     rd_addr/rd_wren       : destination address and write enable
//     wb_valid/wb_rd_addr   : writeback retiring one register write
//     stall, issue          : combinational hold / advance decision
//     busy_vec              : bit i set while register i has pending writes
//     sb_err                : sticky, writeback to a register with no pending write
module reg_scoreboard
  import reg_scoreboard_pkg::*;
#(
  parameter int CNT_W     = SB_CNT_W,
  parameter bit WB_BYPASS = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        id_valid,
  input  logic        id_flush,
  input  r_t          rs1_addr,
  input  r_t          rs2_addr,
  input  logic        rs1_rden,
  input  logic        rs2_rden,
  input  r_t          rd_addr,
  input  logic        rd_wren,
  input  logic        wb_valid,
  input  r_t          wb_rd_addr,
  output logic        stall,
  output logic        issue,
  output logic [31:0] busy_vec,
  output logic        sb_err
);

  logic [NUM_REGS-1:0] w_isZero;
  logic [NUM_REGS-1:0] w_isOne;
  logic [NUM_REGS-1:0] w_isMax;
  logic                w_srcBusy1;
  logic                w_srcBusy2;
  logic                w_raw;
  logic                w_wawOvf;
  logic                w_inc;
  logic                w_dec;
  logic                r_sbErr;

  // x0 is never tracked: it looks permanently idle.
  assign w_isZero[0] = 1'b1;
  assign w_isOne[0]  = 1'b0;
  assign w_isMax[0]  = 1'b0;

  // One counter per tracked register; inc/dec decoded from the addresses.
  for (genvar gi = 1; gi < NUM_REGS; gi++) begin : g_cnt
    sb_counter #(.W(CNT_W)) u_cnt (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_inc     (w_inc && (rd_addr == r_t'(gi))),
      .i_dec     (w_dec && (wb_rd_addr == r_t'(gi))),
      .o_is_zero (w_isZero[gi]),
      .o_is_one  (w_isOne[gi]),
      .o_is_max  (w_isMax[gi])
    );
  end

  // A source is busy while writes are pending, unless the last pending
  // write retires this cycle and the write-through register file hands
  // the value straight to the reader.
  always_comb begin
    w_srcBusy1 = rs1_rden && (rs1_addr != '0) && !w_isZero[rs1_addr];
    w_srcBusy2 = rs2_rden && (rs2_addr != '0) && !w_isZero[rs2_addr];
    if (WB_BYPASS && wb_valid && (wb_rd_addr == rs1_addr) && w_isOne[rs1_addr]) begin
      w_srcBusy1 = 1'b0;
    end
    if (WB_BYPASS && wb_valid && (wb_rd_addr == rs2_addr) && w_isOne[rs2_addr]) begin
      w_srcBusy2 = 1'b0;
    end
  end

  // A saturated destination may still issue when a writeback to the same
  // register frees a slot in the same cycle (inc and dec cancel).
  assign w_raw    = w_srcBusy1 || w_srcBusy2;
  assign w_wawOvf = rd_wren && (rd_addr != '0) && w_isMax[rd_addr] &&
                    !(wb_valid && (wb_rd_addr == rd_addr));

  assign stall = id_valid && !id_flush && (w_raw || w_wawOvf);
  assign issue = id_valid && !id_flush && !stall;

  assign w_inc = issue && rd_wren && (rd_addr != '0);
  assign w_dec = wb_valid && (wb_rd_addr != '0) && !w_isZero[wb_rd_addr];

  // Error latches on a writeback with nothing pending and holds until reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sbErr <= 1'b0;
    end else if (wb_valid && (wb_rd_addr != '0) && w_isZero[wb_rd_addr]) begin
      r_sbErr <= 1'b1;
    end
  end

  assign sb_err   = r_sbErr;
  assign busy_vec = ~w_isZero;

endmodule
